// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arith ops plus an iterative
// multiply/divide unit (shift-add / restoring) writing the HI/LO registers.
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       control,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_b_q;
    logic               is_div_q, neg_res_q, neg_rem_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               seq_code, sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;

    // Operand capture: signed ops work on magnitudes and remember the signs.
    always_comb begin
        seq_code = (control[3:2] == 2'b10);
        sign_a   = ~control[0] & a[WIDTH-1];
        sign_b   = ~control[0] & b[WIDTH-1];
        mag_a    = sign_a ? -a : a;
        mag_b    = sign_b ? -b : b;
    end

    // One iteration. The accumulator low half holds the multiplier (mult) or
    // dividend/quotient (div); the high half holds the partial product or remainder.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            if (div_shift >= {1'b0, mag_b_q}) begin
                acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign correction. MIN/-1 falls out naturally (negating MIN gives MIN), and a
    // zero divisor leaves the remainder equal to the dividend once re-signed.
    always_comb begin
        prod_fix = neg_res_q ? -acc_q : acc_q;
        quo_fix  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            fix_hi = rem_fix;
            fix_lo = (mag_b_q == '0) ? '1 : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_b_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && seq_code) begin
                        acc_q     <= {{WIDTH{1'b0}}, mag_a};
                        mag_b_q   <= mag_b;
                        is_div_q  <= control[1];
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        case (control)
            4'b0000: result = a & b;
            4'b0001: result = a | b;
            4'b0010: result = a + b;
            4'b0110: result = a - b;
            4'b0111: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: result = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1100: result = hi_q;
            4'b1101: result = lo_q;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: result = '0;
            default: result = 'x;
        endcase
    end

    assign zero = (result == '0);
    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed and random checks of a 32-bit and an 8-bit
// instance against an arithmetic reference model.
module tb_alu_muldiv;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]  ctl32;
    logic        st32, z32, busy32, done32;
    logic [31:0] a32, b32, res32, hi32, lo32;
    logic [3:0]  ctl8;
    logic        st8, z8, busy8, done8;
    logic [7:0]  a8, b8, res8, hi8, lo8;

    alu_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .control(ctl32), .start(st32), .a(a32), .b(b32),
        .result(res32), .zero(z32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .control(ctl8), .start(st8), .a(a8), .b(b8),
        .result(res8), .zero(z8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    int passed = 0;
    int total  = 0;

    logic [3:0]  p_op;
    logic [31:0] p_a, p_b;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // HI/LO after a sequential op, from plain integer arithmetic at width w.
    function automatic hl_t ref_seq(input int w, input logic [3:0] op,
                                    input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, half, p, hv, lv;
        longint ua, ub, sa, sb;
        hl_t r;
        mask = (64'd1 << w) - 64'd1;
        half = 64'd1 << (w - 1);
        ua = longint'({32'b0, a} & mask);
        ub = longint'({32'b0, b} & mask);
        sa = (ua >= longint'(half)) ? ua - longint'(64'd1 << w) : ua;
        sb = (ub >= longint'(half)) ? ub - longint'(64'd1 << w) : ub;
        hv = '0;
        lv = '0;
        case (op)
            4'b1000, 4'b1001: begin
                p  = (op == 4'b1000) ? 64'(sa * sb) : 64'(ua * ub);
                lv = p & mask;
                hv = (p >> w) & mask;
            end
            4'b1010: begin
                if (ub == 0) begin
                    lv = mask; hv = 64'(ua);
                end else if (sa == -longint'(half) && sb == -1) begin
                    lv = half; hv = '0;
                end else begin
                    lv = 64'(sa / sb) & mask; hv = 64'(sa % sb) & mask;
                end
            end
            default: begin
                if (ub == 0) begin
                    lv = mask; hv = 64'(ua);
                end else begin
                    lv = 64'(ua / ub) & mask; hv = 64'(ua % ub) & mask;
                end
            end
        endcase
        r.hi = hv[31:0];
        r.lo = lv[31:0];
        return r;
    endfunction

    function automatic logic [31:0] ref_comb(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h,
                                             input logic [31:0] l);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'(longint'(a) + longint'(b));
            4'b0110: return 32'(longint'(a) - longint'(b));
            4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b0011: return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'b1100: return h;
            4'b1101: return l;
            4'b1000, 4'b1001, 4'b1010, 4'b1011: return 32'd0;
            default: return 32'bx;
        endcase
    endfunction

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic comb32(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        ctl32 = op; a32 = a; b32 = b;
        #1;
        check(tag, {32'b0, res32}, {32'b0, exp});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        ctl32 = op; a32 = a; b32 = b; st32 = 1'b1;
        p_op = op; p_a = a; p_b = b;
        @(posedge clk);
        @(negedge clk);
        st32 = 1'b0;
    endtask

    // Waits out busy (bounded), pokes mflo and a stray start mid-flight,
    // and returns at the negedge of the done cycle.
    task automatic finish32(input string tag);
        hl_t e;
        int  n;
        n = 0;
        e = ref_seq(32, p_op, p_a, p_b);
        while (busy32 === 1'b1 && n < 100) begin
            n++;
            if (n == 2) begin
                ctl32 = 4'b1101;
                #1;
                check({tag, "_mflo_busy"}, {32'b0, res32}, {32'b0, m_lo});
                check({tag, "_hi_held"}, {32'b0, hi32}, {32'b0, m_hi});
            end
            if (n == 4) begin
                ctl32 = 4'b1011; a32 = $urandom; b32 = $urandom; st32 = 1'b1;
            end else begin
                st32 = 1'b0;
            end
            @(negedge clk);
        end
        st32 = 1'b0;
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, {63'b0, done32}, 64'd1);
        check({tag, "_hilo"}, {hi32, lo32}, {e.hi, e.lo});
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    task automatic idle32(input string tag);
        @(negedge clk);
        check({tag, "_done_drop"}, {62'b0, done32, busy32}, 64'd0);
    endtask

    task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
        hl_t e;
        int  n;
        e = ref_seq(8, op, {24'b0, a}, {24'b0, b});
        ctl8 = op; a8 = a; b8 = b; st8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st8 = 1'b0;
        n = 0;
        while (busy8 === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd9);
        check({tag, "_done"}, {63'b0, done8}, 64'd1);
        check({tag, "_hilo"}, {48'b0, hi8, lo8}, {48'b0, e.hi[7:0], e.lo[7:0]});
        @(negedge clk);
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] ra, rb, exp;
        logic [3:0]  comb_ops [8];
        int          dones;
        comb_ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0011, 4'b1100, 4'b1101};

        reset = 1'b1;
        ctl32 = '0; st32 = 1'b0; a32 = '0; b32 = '0;
        ctl8 = '0; st8 = 1'b0; a8 = '0; b8 = '0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("reset32", {hi32, lo32}, 64'd0);
        check("reset32_flags", {62'b0, busy32, done32}, 64'd0);
        check("reset8", {46'b0, busy8, done8, hi8, lo8}, 64'd0);

        comb32("add_wrap", 4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        check("add_zero_flag", {63'b0, z32}, 64'd0);
        comb32("sub_eq", 4'b0110, 32'd5, 32'd5, 32'd0);
        check("sub_zero_flag", {63'b0, z32}, 64'd1);
        comb32("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        comb32("sltu_big", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
        comb32("and", 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
        comb32("or", 4'b0001, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
        comb32("seq_code_res", 4'b1010, 32'd3, 32'd4, 32'd0);
        comb32("undef_code", 4'b0101, 32'd3, 32'd4, 32'bx);

        launch32(4'b1000, 32'hFFFF_FFFD, 32'd7);
        finish32("mult_m3x7");
        idle32("mult_m3x7");
        launch32(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish32("multu_max");
        launch32(4'b1010, 32'hFFFF_FFF9, 32'd2);
        finish32("div_m7_2");
        idle32("div_m7_2");
        launch32(4'b1011, 32'd100, 32'd7);
        finish32("divu_100_7");
        launch32(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        finish32("div_ovf");
        launch32(4'b1011, 32'd9, 32'd0);
        finish32("divu_zero");
        idle32("divu_zero");
        comb32("mfhi_after", 4'b1100, 32'd0, 32'd0, m_hi);

        launch32(4'b1000, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort_busy", {62'b0, busy32, done32}, 64'd0);
        check("abort_hilo", {hi32, lo32}, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32 !== 1'b0) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        for (int i = 0; i < 10; i++) begin
            op = 4'b1000 | 4'($urandom_range(0, 3));
            launch32(op, rand_opnd(), rand_opnd());
            finish32($sformatf("rand_seq%0d", i));
            if (i % 2 == 1) idle32($sformatf("rand_seq%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            op  = comb_ops[$urandom_range(0, 7)];
            ra  = rand_opnd();
            rb  = rand_opnd();
            exp = ref_comb(op, ra, rb, m_hi, m_lo);
            comb32($sformatf("rand_comb%0d_op%0h", i, op), op, ra, rb, exp);
            check($sformatf("rand_zero%0d", i), {63'b0, z32}, {63'b0, (exp == 32'd0)});
        end

        run8("w8_mult_min", 4'b1000, 8'h80, 8'hFF);
        run8("w8_div_ovf", 4'b1010, 8'h80, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            run8($sformatf("w8_rand%0d", i), 4'b1000 | 4'($urandom_range(0, 3)),
                 8'($urandom), 8'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
